// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Latency: request seen in IDLE at cycle N -> o_tx_start/o_gnt pulse at N+1; one byte in flight at a time.
// Backpressure: sources hold i_req until their o_gnt pulse; no new grant until i_tx_busy has risen and fallen.
//
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_req, i_req_data per-source request level and byte (source k on bits [8k+7:8k])
//   o_gnt             one-hot, one-cycle pulse when a source's byte is accepted
//   o_tx_start        start pulse to the transmitter; o_tx_data is the latched byte
//   i_tx_busy         transmitter busy flag
//   o_active          high whenever the controller is not idle
//   o_src             index of the most recently granted source
//   o_err             sticky watchdog flag (only when UART_TX_ARB_WATCHDOG_EN is defined)
//
// Optional feature macro: UART_TX_ARB_WATCHDOG_EN bounds the two wait states and
// reports a stuck transmitter on o_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_active,
  output logic [IDX_W-1:0]     o_src
`ifdef UART_TX_ARB_WATCHDOG_EN
  ,
  output logic                 o_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [IDX_W-1:0]     src_q, src_d;

  // Arbitration results
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [7:0]           win_dat;
  logic [IDX_W:0]       cand;
  logic [IDX_W:0]       src_inc;

`ifdef UART_TX_ARB_WATCHDOG_EN
  // Last cycle index allowed in each wait state before giving up on the transmitter.
  localparam logic [4:0] WD_BUSY_LAST = 5'd3;
  localparam logic [4:0] WD_DONE_LAST = 5'd31;

  logic [4:0]           wd_cnt_q, wd_cnt_d;
  logic                 err_q, err_d;
`endif

  // Scan upward from rr_ptr with wraparound; the first set request wins.
  // One extra index bit keeps ptr+i from overflowing before the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && i_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Byte mux for the winning source.
  always_comb begin
    win_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_dat = i_req_data[8*k +: 8];
      end
    end
  end

  // Pointer moves just past the granted source, so it has lowest priority next time.
  always_comb begin
    src_inc = {1'b0, src_q} + {{IDX_W{1'b0}}, 1'b1};
    if (src_inc == NUM_REQ_W) begin
      src_inc = '0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = 1'b0;
    gnt_d      = '0;
    tx_data_d  = tx_data_q;
    src_d      = src_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
    err_d      = err_q;
    wd_cnt_d   = wd_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // The transmitter is not reset with us, so a frame left over from
        // before a reset must drain before we start another.
        if (win_found && !i_tx_busy) begin
          tx_data_d  = win_dat;
          src_d      = win_idx;
          // start/gnt are registered: they appear while in START.
          tx_start_d = 1'b1;
          gnt_d      = NUM_REQ'(1) << win_idx;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        rr_ptr_d = src_inc[IDX_W-1:0];
        state_d  = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_BUSY_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end

      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = ST_IDLE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_DONE_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Counts cycles spent in the current state; restarts on any transition.
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 5'd1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      tx_start_q <= 1'b0;
      gnt_q      <= '0;
      tx_data_q  <= '0;
      src_q      <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_start_q <= tx_start_d;
      gnt_q      <= gnt_d;
      tx_data_q  <= tx_data_d;
      src_q      <= src_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign o_gnt      = gnt_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_src      = src_q;
  assign o_active   = (state_q != ST_IDLE);
`ifdef UART_TX_ARB_WATCHDOG_EN
  assign o_err      = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: directed scenarios plus random request traffic,
// with a transaction-level reference model feeding a scoreboard of expected grants.
// Includes a simple transmitter model that holds busy for one frame per start.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int FRAME = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           active;
  logic [IW-1:0]  src;
`ifdef UART_TX_ARB_WATCHDOG_EN
  logic           err;
`endif

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_data (req_data),
    .o_gnt      (gnt),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy),
    .o_active   (active),
    .o_src      (src)
`ifdef UART_TX_ARB_WATCHDOG_EN
    ,
    .o_err      (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after a start and lasts FRAME cycles.
  int tx_cnt  = 0;
  bit tx_dead = 1'b0;
  always @(posedge clk) begin
    if (tx_start && tx_cnt == 0 && !tx_dead) tx_cnt <= FRAME;
    else if (tx_cnt > 0)                     tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = (tx_cnt != 0) && !tx_dead;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         c;
    logic [N-1:0] g;
    logic [7:0] d;
    int         s;
  } exp_t;

  exp_t         expq[$];
  int           src_log[$];
  int           start_cyc[$];
  logic [N-1:0] gnt_seen = '0;
  int           m_ptr   = 0;
  int           free_at = 0;

  // Monitor + reference model, both evaluated mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int   w;
    gnt_seen = gnt;
    if (tx_start || gnt != '0) begin
      if (expq.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("start_cycle", cyc, e.c);
        chk("gnt", gnt, e.g);
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, e.d);
        chk("src", src, e.s);
      end
      src_log.push_back(int'(src));
      start_cyc.push_back(cyc);
    end
    // Model: when free and a request is pending with the line idle, the next
    // source in round-robin order is served one cycle later.
    if (rst) begin
      expq.delete();
      m_ptr   = 0;
      free_at = cyc + 1;
    end else if (cyc >= free_at && req != '0 && !tx_busy) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      e.c = cyc + 1;
      e.g = N'(1) << w;
      e.d = req_data[8*w +: 8];
      e.s = w;
      expq.push_back(e);
      m_ptr = (w + 1) % N;
      // Start cycle, then busy for a frame, then one cycle to observe it low.
      // A dead transmitter is abandoned after four WAIT_BUSY cycles.
      free_at = tx_dead ? cyc + 6 : cyc + 3 + FRAME;
    end
  end

  logic [N-1:0] keep;

  // One clock; a source drops its request after its grant unless told to keep it.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (gnt_seen[k] && !keep[k]) req[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      step();
      if (gnt_seen != '0) found = 1'b1;
    end
    chk("gnt_arrived", found, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      if (!active && !tx_busy) done = 1'b1;
    end
    chk("idle_reached", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bad;
    int s0;
    bit found;
    rst      = 1'b1;
    req      = '0;
    keep     = '0;
    req_data = '0;
    repeat (3) step();

    // Reset values
    chk("rst_gnt", gnt, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_src", src, 0);
    chk("rst_active", active, 0);
`ifdef UART_TX_ARB_WATCHDOG_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b0;
    step();

    // Single request from source 2
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    wait_gnt(5);
    chk("single_src", src, 2);
    chk("single_data", tx_data, 8'hA5);
    chk("single_active", active, 1);
    wait_idle(30);

    // All sources requesting continuously
    do_reset();
    req_data = 32'h13121110;
    src_log.delete();
    start_cyc.delete();
    keep = '1;
    req  = '1;
    for (int n = 0; n < 120 && src_log.size() < 5; n++) step();
    keep = '0;
    req  = '0;
    chk("rr_count", src_log.size(), 5);
    if (src_log.size() >= 5) begin
      chk("rr_order0", src_log[0], 0);
      chk("rr_order1", src_log[1], 1);
      chk("rr_order2", src_log[2], 2);
      chk("rr_order3", src_log[3], 3);
      chk("rr_order4", src_log[4], 0);
      for (int i = 1; i < 5; i++) chk("rr_spacing", start_cyc[i] - start_cyc[i-1], FRAME + 3);
    end
    wait_idle(30);

    // Pointer wrap: after source 3, sources 0 and 3 both request
    do_reset();
    req_data = 32'hD3C2B1A0;
    req = 4'b1000;
    wait_gnt(5);
    wait_idle(30);
    src_log.delete();
    req = 4'b1001;
    for (int n = 0; n < 60 && src_log.size() < 2; n++) step();
    chk("wrap_count", src_log.size(), 2);
    if (src_log.size() >= 2) begin
      chk("wrap_first", src_log[0], 0);
      chk("wrap_second", src_log[1], 3);
    end
    wait_idle(30);

    // Reset while the frame is in flight
    req = 4'b0010;
    wait_gnt(5);
    repeat (4) step();
    chk("mid_active", active, 1);
    chk("mid_busy", tx_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_gnt", gnt, 0);
    chk("mrst_tx_start", tx_start, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_src", src, 0);
    chk("mrst_active", active, 0);
    req = 4'b0010;
    bad   = 0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (tx_start && tx_busy) bad++;
      if (gnt_seen[1]) found = 1'b1;
    end
    chk("mrst_regrant", found, 1);
    chk("mrst_start_while_busy", bad, 0);
    wait_idle(30);

    // Request pulse during WAIT_DONE is ignored
    req_data[7:0] = 8'h3C;
    req = 4'b0001;
    wait_gnt(5);
    repeat (5) step();
    req_data[23:16] = 8'hEE;
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    src_log.delete();
    wait_idle(30);
    chk("ignore_no_gnt", src_log.size(), 0);
    chk("ignore_data", tx_data, 8'h3C);

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Dead transmitter: busy never rises
    tx_dead = 1'b1;
    do_reset();
    keep = 4'b0001;
    req  = 4'b0001;
    wait_gnt(5);
    s0 = start_cyc[start_cyc.size()-1];
    while (cyc < s0 + 4) step();
    chk("wd_err_before", err, 0);
    step();
    chk("wd_err_set", err, 1);
    chk("wd_idle", active, 0);
    wait_gnt(5);
    chk("wd_regrant_gap", start_cyc[start_cyc.size()-1] - s0, 6);
    keep = '0;
    req  = '0;
    wait_idle(30);
    chk("wd_err_sticky", err, 1);
    tx_dead = 1'b0;
    do_reset();
    chk("wd_err_cleared", err, 0);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < N; k++) begin
        keep[k] = ($urandom_range(0, 3) == 0);
        if (!req[k]) begin
          if ($urandom_range(0, 99) < 15) begin
            req_data[8*k +: 8] = 8'($urandom);
            req[k] = 1'b1;
          end
        end else if ($urandom_range(0, 99) < 2) begin
          req[k] = 1'b0;
        end
      end
      step();
    end
    keep = '0;
    req  = '0;
    wait_idle(40);
    repeat (3) step();
    chk("scoreboard_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
